// File: rtl/dpll_freq_ctrl.sv
// DPLL retune sequencer: applies a requested select, waits for settling, then qualifies
// and monitors lock by counting synchronised fout edges over fixed windows.
module dpll_freq_ctrl #(
  parameter int SETTLE_CYCLES = 2000,
  parameter int WINDOW_CYCLES = 1024,
  parameter int EXP_CNT_0     = 64,
  parameter int EXP_CNT_1     = 128,
  parameter int EXP_CNT_2     = 192,
  parameter int EXP_CNT_3     = 256,
  parameter int TOL           = 2,
  parameter int LOCK_WINDOWS  = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  input  logic       fout_i,
  output logic [1:0] freq_select,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic       lost_lock
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int MW = $clog2(LOCK_WINDOWS + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WINDOW_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [MW-1:0] LOCK_N      = MW'(LOCK_WINDOWS);
  localparam logic [RW-1:0] RETRY_N     = RW'(MAX_RETRY);
  localparam logic [16:0]   TOL_V       = 17'(TOL);
  localparam int EXP_CNT [4] = '{EXP_CNT_0, EXP_CNT_1, EXP_CNT_2, EXP_CNT_3};

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_MEASURE, S_LOCKED, S_FAIL
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      freq_select_reg, freq_select_next;
  logic [1:0]      cur_sel_reg, cur_sel_next;
  logic            locked_reg, locked_next;
  logic            fail_reg, fail_next;
  logic            lost_lock_reg, lost_lock_next;
  logic [SW-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [WW-1:0]   win_cnt_reg, win_cnt_next;
  logic [15:0]     edge_cnt_reg, edge_cnt_next;
  logic [MW-1:0]   match_cnt_reg, match_cnt_next;
  logic [RW-1:0]   retry_cnt_reg, retry_cnt_next;
  logic [1:0]      sync_reg;
  logic            prev_reg;

  logic [15:0]     exp_tbl [4];
  logic            fout_edge;
  logic            accept;
  logic            win_last;
  logic            win_match;
  logic [15:0]     cnt_total;
  logic [16:0]     diff;
  logic [16:0]     abs_diff;
  logic [MW-1:0]   match_inc;
  logic [RW-1:0]   retry_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_exp
      assign exp_tbl[gi] = 16'(EXP_CNT[gi]);
    end
  endgenerate

  assign fout_edge = sync_reg[1] & ~prev_reg;
  assign req_ready = (state_reg == S_IDLE) || (state_reg == S_LOCKED) || (state_reg == S_FAIL);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;
  assign win_last  = (win_cnt_reg == WINDOW_LAST);
  assign match_inc = match_cnt_reg + MW'(1);
  assign retry_inc = retry_cnt_reg + RW'(1);

  // Window count includes an edge landing on the final window cycle; saturates at all-ones.
  assign cnt_total = (fout_edge && edge_cnt_reg != 16'hFFFF) ? edge_cnt_reg + 16'd1 : edge_cnt_reg;
  assign diff      = {1'b0, cnt_total} - {1'b0, exp_tbl[cur_sel_reg]};
  assign abs_diff  = diff[16] ? (~diff + 17'd1) : diff;
  assign win_match = (cnt_total != 16'hFFFF) && (abs_diff <= TOL_V);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    freq_select_next = freq_select_reg;
    cur_sel_next     = cur_sel_reg;
    locked_next      = locked_reg;
    fail_next        = fail_reg;
    lost_lock_next   = 1'b0;
    settle_cnt_next  = settle_cnt_reg;
    win_cnt_next     = win_cnt_reg;
    edge_cnt_next    = edge_cnt_reg;
    match_cnt_next   = match_cnt_reg;
    retry_cnt_next   = retry_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          cur_sel_next = req_sel;
          state_next   = S_APPLY;
        end
      end
      S_APPLY: begin
        freq_select_next = cur_sel_reg;
        settle_cnt_next  = '0;
        win_cnt_next     = '0;
        edge_cnt_next    = '0;
        match_cnt_next   = '0;
        retry_cnt_next   = '0;
        state_next       = S_SETTLE;
      end
      S_SETTLE: begin
        edge_cnt_next = '0;
        win_cnt_next  = '0;
        if (settle_cnt_reg == SETTLE_LAST) state_next = S_MEASURE;
        else settle_cnt_next = settle_cnt_reg + SW'(1);
      end
      S_MEASURE: begin
        if (win_last) begin
          win_cnt_next  = '0;
          edge_cnt_next = '0;
          if (win_match) begin
            match_cnt_next = match_inc;
            if (match_inc == LOCK_N) begin
              locked_next = 1'b1;
              state_next  = S_LOCKED;
            end
          end else begin
            match_cnt_next  = '0;
            retry_cnt_next  = retry_inc;
            settle_cnt_next = '0;
            if (retry_inc == RETRY_N) begin
              fail_next  = 1'b1;
              state_next = S_FAIL;
            end else begin
              state_next = S_SETTLE;
            end
          end
        end else begin
          win_cnt_next  = win_cnt_reg + WW'(1);
          edge_cnt_next = cnt_total;
        end
      end
      S_LOCKED: begin
        // A new request wins over whatever the closing window says.
        if (accept) begin
          locked_next  = 1'b0;
          cur_sel_next = req_sel;
          state_next   = S_APPLY;
        end else if (win_last) begin
          win_cnt_next  = '0;
          edge_cnt_next = '0;
          if (!win_match) begin
            locked_next     = 1'b0;
            lost_lock_next  = 1'b1;
            retry_cnt_next  = '0;
            match_cnt_next  = '0;
            settle_cnt_next = '0;
            state_next      = S_SETTLE;
          end
        end else begin
          win_cnt_next  = win_cnt_reg + WW'(1);
          edge_cnt_next = cnt_total;
        end
      end
      S_FAIL: begin
        if (accept) begin
          fail_next    = 1'b0;
          cur_sel_next = req_sel;
          state_next   = S_APPLY;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      freq_select_reg <= '0;
      cur_sel_reg     <= '0;
      locked_reg      <= 1'b0;
      fail_reg        <= 1'b0;
      lost_lock_reg   <= 1'b0;
      settle_cnt_reg  <= '0;
      win_cnt_reg     <= '0;
      edge_cnt_reg    <= '0;
      match_cnt_reg   <= '0;
      retry_cnt_reg   <= '0;
      sync_reg        <= '0;
      prev_reg        <= 1'b0;
    end else begin
      freq_select_reg <= freq_select_next;
      cur_sel_reg     <= cur_sel_next;
      locked_reg      <= locked_next;
      fail_reg        <= fail_next;
      lost_lock_reg   <= lost_lock_next;
      settle_cnt_reg  <= settle_cnt_next;
      win_cnt_reg     <= win_cnt_next;
      edge_cnt_reg    <= edge_cnt_next;
      match_cnt_reg   <= match_cnt_next;
      retry_cnt_reg   <= retry_cnt_next;
      sync_reg        <= {sync_reg[0], fout_i};
      prev_reg        <= sync_reg[1];
    end
  end

  assign freq_select = freq_select_reg;
  assign cur_sel     = cur_sel_reg;
  assign locked      = locked_reg;
  assign fail        = fail_reg;
  assign lost_lock   = lost_lock_reg;

endmodule
